ed25519_addsub_modp_pipe: RTL
=============================

# ed25519_addsub_modp_pipe

Elastic, parametrised modular add/subtract unit for the sigverify datapath, computing (a ± b) mod P for canonical operands. It supersedes the fixed, free-running add-mod-p stage with a per-transaction add/sub mode, a parameter-selectable modulus, valid/ready backpressure and a non-canonical input flag. It sits between the point-arithmetic schedulers and the field multiplier pipes, carrying opaque metadata alongside each result.

## Interface
Parameters:
- W, 255, operand/result width in bits; P < 2^W
- M, 128, metadata width carried alongside each operation
- P, ED25519_P, modulus (W bits)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  input transaction valid
- i_ready  out  1  input accepted when i_valid & i_ready
- i_op  in  1  0 = add (a+b), 1 = subtract (a-b)
- i_a  in  W  operand a
- i_b  in  W  operand b
- i_m  in  M  metadata, returned unchanged
- o_valid  out  1  result valid
- o_ready  in  1  consumer ready
- o_data  out  W  result, always in [0, P)
- o_m  out  M  metadata of this result
- o_err  out  1  set if i_a >= P or i_b >= P for this transaction

## Operation
- Stage 1 (S1 register), on accept:
  - add: s = {0,a} + {0,b} (W+1 bits)
  - sub: s = {0,a} - {0,b} (W+1 bits, two's complement); borrow = s[W]
  - Captures op, m, and err = (a >= P) | (b >= P).
- Stage 2 (S2 = output register), reduction:
  - add: result = (s >= P) ? s - P : s
  - sub: result = borrow ? s + P : s
  - Result is truncated to W bits.
- Arithmetic is exact for canonical inputs.
  - Non-canonical inputs still yield a deterministic value: the same formula, truncated to W bits.
  - o_err is asserted with that result; no other action is taken.
- Elastic pipeline rules:
  - Each stage has a valid bit (v1, v2). S2 advances when ~v2 | o_ready; S1 advances when ~v1 | S2 advances.
  - i_ready = rst_n & (~v1 | S1 advances). It is combinational from o_ready; no skid buffer is needed.
  - While o_valid & ~o_ready, o_data, o_m and o_err hold stable.
  - Transactions are strictly in order; none are lost or duplicated.
- Simultaneous accept and drain at a full pipeline gives full throughput of one operation per cycle.
- Reset:
  - rst_n low asynchronously clears v1 and v2, o_data, o_m and o_err to 0.
  - i_ready is 0 while rst_n is low.
  - In-flight transactions are discarded.
  - On deassertion, i_ready is 1 in the first cycle.

## Timing
- Latency is 2 cycles: a transaction accepted at edge N presents o_valid after edge N+2 when unstalled.
- Throughput is 1 transaction/cycle with o_ready held high.
- Capacity is 2 transactions. With o_ready low, i_ready falls once v1 and v2 are both set.
- Reset values: o_valid 0, o_data 0, o_m 0, o_err 0, i_ready 0 (while in reset).
- Critical path: the W+1-bit compare/add in S2.
  - The compare is implemented as the carry-out of s + (2^(W+1) - P).
  - Both reduce candidates are computed in parallel and then muxed.

## Structure
- Package wd_sigverify holds ED25519_P and a typedef for the op encoding (ADD=0, SUB=1).
- The negated-modulus constant (2^(W+1) - P) is derived inside the module from the P parameter, so non-Ed25519 moduli work unchanged.
- One sub-module, piped_adder, is instantiated with R=0 and C=1 for both the S1 add/sub and the S2 reduction adder.
  - Stage enable and valid/ready control live in this module.
  - Subtraction is formed as a + ~b + 1.
- Target size is roughly 150-250 lines.

## Test plan
- Add wrap: a=P-1, b=1, op=0 -> o_data=0, o_err=0, two cycles after accept. Also a=P-1, b=P-1 -> P-2.
- Sub borrow: a=0, b=1, op=1 -> P-1. Also a=5, b=3 -> 2; a=b=P-1 -> 0.
- Backpressure: hold o_ready=0 and offer 4 back-to-back ops (m=1..4).
  - Only 2 are accepted and i_ready drops.
  - Outputs stay stable while stalled.
  - Releasing o_ready yields m=1..4 in order, one per cycle.
- Non-canonical: a=P, b=0, op=0 -> o_data=0, o_err=1. The next canonical op has o_err=0.
- Reset mid-flight: assert rst_n low between clock edges with v1=v2=1.
  - o_valid, o_data, o_m and o_err go to 0 immediately.
  - After release, no stale result appears and a new op completes with 2-cycle latency.
- Random soak: 10^5 random canonical add/sub ops with random o_ready/i_valid gaps, checked against a reference model; metadata must match in order.

Source files
------------

// File: rtl/wd_sigverify.sv
// Shared constants and encodings for the sigverify field-arithmetic datapath.
package wd_sigverify;

  localparam int unsigned ED25519_W = 255;

  // 2^255 - 19
  localparam logic [ED25519_W-1:0] ED25519_P = {ED25519_W{1'b1}} - ED25519_W'(18);

  typedef enum logic {
    OpAdd = 1'b0,
    OpSub = 1'b1
  } op_e;

endpackage

// File: rtl/piped_adder.sv
// W-bit adder with carry-in, optional carry-out and R optional output register stages.
module piped_adder #(
  parameter int unsigned W = 256,
  parameter int unsigned R = 0,
  parameter int unsigned C = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] full;
  logic [W:0] res;

  assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

  if (R == 0) begin : g_comb
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, en};
    assign res = full;
  end else begin : g_reg
    logic [W:0] pipe_q [R];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < R; i++) pipe_q[i] <= '0;
      end else if (en) begin
        pipe_q[0] <= full;
        for (int i = 1; i < R; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign res = pipe_q[R-1];
  end

  assign sum  = res[W-1:0];
  assign cout = (C != 0) ? res[W] : 1'b0;

endmodule

// File: rtl/ed25519_addsub_modp_pipe.sv
// Two-stage elastic (a +/- b) mod P unit: S1 forms the raw sum/difference, S2 reduces it.
module ed25519_addsub_modp_pipe
  import wd_sigverify::*;
#(
  parameter int unsigned W = 255,
  parameter int unsigned M = 128,
  parameter logic [W-1:0] P = ED25519_P
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         i_ready,
  input  logic         i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [M-1:0] i_m,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [W-1:0] o_data,
  output logic [M-1:0] o_m,
  output logic         o_err
);

  localparam logic [W:0] PExt = {1'b0, P};
  // Adding 2^(W+1) - P carries out exactly when s >= P.
  localparam logic [W:0] NegP = ~PExt + (W+1)'(1);

  logic         s2_adv, s1_adv, accept;
  logic         v1_q, v1_d, v2_q, v2_d;
  op_e          op1_q;
  logic [W:0]   s1_q;
  logic [M-1:0] m1_q;
  logic         err1_q;
  logic [W-1:0] data2_q;
  logic [M-1:0] m2_q;
  logic         err2_q;

  logic [W:0]   b_in, s1_sum, s_minus_p, s_plus_p;
  logic         err_in, ge_p;
  logic [W-1:0] red;
  logic         unused_s1_cout, unused_wrap_cout, unused_hi;

  assign s2_adv  = ~v2_q | o_ready;
  assign s1_adv  = ~v1_q | s2_adv;
  assign i_ready = rst_n & s1_adv;
  assign accept  = i_valid & i_ready;
  assign v1_d    = s1_adv ? accept : v1_q;
  assign v2_d    = s2_adv ? v1_q : v2_q;

  // Subtraction as a + ~b + 1 over W+1 bits; bit W of the result is the borrow.
  assign b_in   = (op_e'(i_op) == OpSub) ? ~{1'b0, i_b} : {1'b0, i_b};
  assign err_in = (i_a >= P) | (i_b >= P);

  piped_adder #(
    .W(W + 1),
    .R(0),
    .C(1)
  ) u_s1_add (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (1'b1),
    .a    ({1'b0, i_a}),
    .b    (b_in),
    .cin  (i_op),
    .sum  (s1_sum),
    .cout (unused_s1_cout)
  );

  piped_adder #(
    .W(W + 1),
    .R(0),
    .C(1)
  ) u_s2_cmp (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (1'b1),
    .a    (s1_q),
    .b    (NegP),
    .cin  (1'b0),
    .sum  (s_minus_p),
    .cout (ge_p)
  );

  piped_adder #(
    .W(W + 1),
    .R(0),
    .C(1)
  ) u_s2_wrap (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (1'b1),
    .a    (s1_q),
    .b    (PExt),
    .cin  (1'b0),
    .sum  (s_plus_p),
    .cout (unused_wrap_cout)
  );

  assign unused_hi = s_minus_p[W] ^ s_plus_p[W];

  always_comb begin
    red = s1_q[W-1:0];
    if (op1_q == OpAdd) begin
      if (ge_p) red = s_minus_p[W-1:0];
    end else if (s1_q[W]) begin
      red = s_plus_p[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      op1_q   <= OpAdd;
      s1_q    <= '0;
      m1_q    <= '0;
      err1_q  <= 1'b0;
      data2_q <= '0;
      m2_q    <= '0;
      err2_q  <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      if (accept) begin
        op1_q  <= op_e'(i_op);
        s1_q   <= s1_sum;
        m1_q   <= i_m;
        err1_q <= err_in;
      end
      if (s2_adv && v1_q) begin
        data2_q <= red;
        m2_q    <= m1_q;
        err2_q  <= err1_q;
      end
    end
  end

  assign o_valid = v2_q;
  assign o_data  = data2_q;
  assign o_m     = m2_q;
  assign o_err   = err2_q;

endmodule
